alu_sequencer: RTL

Program sequencer for the 16-bit Q8.7 ALU. On a start pulse it walks a program of up to 2^IMEM_AW instructions. For each step it:
- fetches the instruction and its operand pair from synchronous-read memories,
- issues one enabled cycle to the ALU,
- writes the ALU result to the output memory at the same index.

It sits between the instruction/operand memories, the ALU and the result memory, and is the only driver of the ALU's enable, instruction and operand inputs.

---
 rtl/alu_sequencer_pkg.sv | 31 +++
 rtl/alu_sequencer_if.sv | 29 ++
 rtl/alu_sequencer.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/alu_sequencer_pkg.sv
// alu_seq_pkg: shared types and constants for the ALU program sequencer.
//   - state_t   : sequencer FSM states
//   - OP_*      : ALU opcode encodings carried in instruction bits [2:0]
//   - HALT_BIT  : instruction bit that marks a halt (used when ALU_SEQ_HALT_EN is defined)
//   - DATA_W    : width of the Q8.7 operand/result words
//   - INS_W     : instruction width
package alu_seq_pkg;

  localparam int DATA_W   = 16;
  localparam int INS_W    = 8;
  localparam int HALT_BIT = 7;

  localparam logic [2:0] OP_NOP = 3'd0;
  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_SUB = 3'd2;
  localparam logic [2:0] OP_MUL = 3'd3;
  localparam logic [2:0] OP_AND = 3'd4;
  localparam logic [2:0] OP_OR  = 3'd5;
  localparam logic [2:0] OP_NOT = 3'd6;
  localparam logic [2:0] OP_XOR = 3'd7;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LOAD  = 3'd2,
    EXEC  = 3'd3,
    WB    = 3'd4,
    DONE  = 3'd5
  } state_t;

endpackage

// File: rtl/alu_sequencer_if.sv
// alu_sequencer_if: bus between the program sequencer and the Q8.7 ALU.
//   alu_en_out      sequencer -> ALU  one-cycle execute enable
//   alu_ins_out     sequencer -> ALU  instruction (bits [2:0] opcode)
//   alu_a_out/b_out sequencer -> ALU  signed operands
//   alu_c_in        ALU -> sequencer  signed result (one cycle after enable)
//   alu_c_valid_in  ALU -> sequencer  result valid
// Modports: master = sequencer side, slave = ALU side.
interface alu_sequencer_if
  import alu_seq_pkg::*;
  ();

  logic                     alu_en_out;
  logic [INS_W-1:0]         alu_ins_out;
  logic signed [DATA_W-1:0] alu_a_out;
  logic signed [DATA_W-1:0] alu_b_out;
  logic signed [DATA_W-1:0] alu_c_in;
  logic                     alu_c_valid_in;

  modport master (
    output alu_en_out, alu_ins_out, alu_a_out, alu_b_out,
    input  alu_c_in, alu_c_valid_in
  );

  modport slave (
    input  alu_en_out, alu_ins_out, alu_a_out, alu_b_out,
    output alu_c_in, alu_c_valid_in
  );

endinterface

// File: rtl/alu_sequencer.sv
// alu_sequencer: walks a program of up to 2^AW instructions. Each step fetches
// the instruction and operand pair (1-cycle synchronous-read memories), gives the
// ALU one enabled cycle and writes the result to the output memory at the same
// index. Four cycles per instruction: FETCH, LOAD, EXEC, WB.
//
// Optional feature: define ALU_SEQ_HALT_EN to make instruction bit 7 a halt
// marker (the instruction still executes and writes, then the run ends).
//
// Ports:
//   CLK, RST (async, active-low)
//   start_in, prog_len_in[AW:0]       run request and instruction count
//   busy_out, done_out, err_out       status (err_out sticky until next run)
//   imem_addr_out, imem_data_in       instruction memory read port
//   dmem_addr_out, dmem_a_in/b_in     operand memory read port
//   alu (alu_sequencer_if.master)     ALU enable/instruction/operands/result
//   omem_we_out/addr_out/data_out     result memory write port
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int AW = 4
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     start_in,
  input  logic [AW:0]              prog_len_in,
  output logic                     busy_out,
  output logic                     done_out,
  output logic                     err_out,
  output logic [AW-1:0]            imem_addr_out,
  input  logic [INS_W-1:0]         imem_data_in,
  output logic [AW-1:0]            dmem_addr_out,
  input  logic signed [DATA_W-1:0] dmem_a_in,
  input  logic signed [DATA_W-1:0] dmem_b_in,
  alu_sequencer_if.master          alu,
  output logic                     omem_we_out,
  output logic [AW-1:0]            omem_addr_out,
  output logic signed [DATA_W-1:0] omem_data_out
);

  state_t                   state_q, state_d;
  logic [AW-1:0]            pc_q, pc_d;
  logic [AW:0]              len_q, len_d;
  logic [INS_W-1:0]         ins_q, ins_d;
  logic signed [DATA_W-1:0] a_q, a_d;
  logic signed [DATA_W-1:0] b_q, b_d;
  logic                     err_q, err_d;
  logic                     busy_q, busy_d;
  logic                     alu_en;
  logic                     is_last;
  logic                     halt;

  // Compared at AW+1 bits so a full 2^AW program ends at pc = 2^AW-1
  // without pc ever wrapping.
  assign is_last = ({1'b0, pc_q} == (len_q - (AW+1)'(1)));

`ifdef ALU_SEQ_HALT_EN
  assign halt = ins_q[HALT_BIT];
`else
  assign halt = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      pc_q    <= '0;
      len_q   <= '0;
      ins_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      len_q   <= len_d;
      ins_q   <= ins_d;
      a_q     <= a_d;
      b_q     <= b_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    len_d         = len_q;
    ins_d         = ins_q;
    a_d           = a_q;
    b_d           = b_q;
    err_d         = err_q;
    busy_d        = busy_q;
    alu_en        = 1'b0;
    omem_we_out   = 1'b0;
    omem_data_out = '0;
    done_out      = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_in) begin
          if (prog_len_in != '0) begin
            len_d   = prog_len_in;
            pc_d    = '0;
            err_d   = 1'b0;
            busy_d  = 1'b1;
            state_d = FETCH;
          end else begin
            // Empty program: report completion without touching memories.
            state_d = DONE;
          end
        end
      end
      FETCH: state_d = LOAD;
      LOAD: begin
        ins_d   = imem_data_in;
        a_d     = dmem_a_in;
        b_d     = dmem_b_in;
        state_d = EXEC;
      end
      EXEC: begin
        alu_en  = 1'b1;
        state_d = WB;
      end
      WB: begin
        if (alu.alu_c_valid_in) begin
          omem_we_out   = 1'b1;
          omem_data_out = alu.alu_c_in;
          if (is_last || halt) begin
            state_d = DONE;
          end else begin
            pc_d    = pc_q + 1'b1;
            state_d = FETCH;
          end
        end else begin
          // Missing result aborts the run and is remembered until the next run.
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        done_out = 1'b1;
        busy_d   = 1'b0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Addresses follow pc directly; the memories only act on them in FETCH/WB.
  assign imem_addr_out   = pc_q;
  assign dmem_addr_out   = pc_q;
  assign omem_addr_out   = pc_q;
  assign busy_out        = busy_q;
  assign err_out         = err_q;

  // Operand registers hold their values outside EXEC, so the ALU inputs do too.
  assign alu.alu_en_out  = alu_en;
  assign alu.alu_ins_out = ins_q;
  assign alu.alu_a_out   = a_q;
  assign alu.alu_b_out   = b_q;

endmodule
